// File: rtl/e203_nice_csr_pkg.sv
// Shared constants for the NICE CSR arbiter: data/address width and FSM encoding.
package e203_nice_csr_pkg;

    localparam int CSR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } csr_state_e;

endpackage

// File: rtl/e203_nice_csr_arb_if.sv
// Downstream NICE CSR handshake bus; the arbiter is the master, the extended-CSR block the slave.
interface e203_nice_csr_arb_if;
    import e203_nice_csr_pkg::*;

    logic             nice_csr_valid;
    logic             nice_csr_ready;
    logic [CSR_W-1:0] nice_csr_addr;
    logic             nice_csr_wr;
    logic [CSR_W-1:0] nice_csr_wdata;
    logic [CSR_W-1:0] nice_csr_rdata;

    modport master (
        output nice_csr_valid, nice_csr_addr, nice_csr_wr, nice_csr_wdata,
        input  nice_csr_ready, nice_csr_rdata
    );

    modport slave (
        input  nice_csr_valid, nice_csr_addr, nice_csr_wr, nice_csr_wdata,
        output nice_csr_ready, nice_csr_rdata
    );

endinterface

// File: rtl/e203_nice_csr_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr+1, wrapping.
module e203_nice_csr_rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Offset N_REQ lands back on ptr itself, so the last winner ranks lowest.
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/e203_nice_csr_arb.sv
// Round-robin arbiter sharing one NICE CSR port among N_REQ requesters, with optional timeout.
module e203_nice_csr_arb
    import e203_nice_csr_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int TO_CYC = 16,
    parameter int TO_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*CSR_W-1:0] req_addr,
    input  logic [N_REQ-1:0]       req_wr,
    input  logic [N_REQ*CSR_W-1:0] req_wdata,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [CSR_W-1:0]       rsp_rdata,
    output logic                   rsp_err,
    e203_nice_csr_arb_if.master    csr
);

    localparam int              IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam bit              TO_EN   = (TO_CYC != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TO_CYC > 0) ? TO_CYC - 1 : 0);

    csr_state_e       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win_idx;
    logic [TO_W-1:0]  cnt;
    logic [CSR_W-1:0] addr_q;
    logic             wr_q;
    logic [CSR_W-1:0] wdata_q;
    logic             csr_vld_q;

    logic [N_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [N_REQ-1:0] win_oh;

    e203_nice_csr_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign req_ready = (state == IDLE) ? pick_gnt : '0;
    assign win_oh    = N_REQ'(1) << win_idx;

    assign csr.nice_csr_valid = csr_vld_q;
    assign csr.nice_csr_addr  = addr_q;
    assign csr.nice_csr_wr    = wr_q;
    assign csr.nice_csr_wdata = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= IDX_W'(N_REQ - 1);
            win_idx   <= '0;
            cnt       <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            csr_vld_q <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        addr_q    <= req_addr[CSR_W*int'(pick_idx) +: CSR_W];
                        wr_q      <= req_wr[pick_idx];
                        wdata_q   <= req_wdata[CSR_W*int'(pick_idx) +: CSR_W];
                        win_idx   <= pick_idx;
                        ptr       <= pick_idx;
                        cnt       <= '0;
                        csr_vld_q <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Ready is tested first so it beats a timeout landing in the same cycle.
                    if (csr.nice_csr_ready) begin
                        rsp_rdata <= wr_q ? '0 : csr.nice_csr_rdata;
                        rsp_err   <= 1'b0;
                        rsp_valid <= win_oh;
                        csr_vld_q <= 1'b0;
                        state     <= RESP;
                    end else if (TO_EN && cnt == TO_LAST) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= win_oh;
                        csr_vld_q <= 1'b0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e203_nice_csr_arb.sv
// Directed bench: two arbiters (TO_CYC=16 and TO_CYC=4) with a response scoreboard per instance.
module tb_e203_nice_csr_arb;
    import e203_nice_csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  vld_a, vld_b, rr_a, rr_b, rv_a, rv_b, wr;
    logic [63:0] addr, wdata;
    logic [31:0] rd_a, rd_b;
    logic        err_a, err_b;
    logic [1:0]  rr_oh;

    typedef struct {
        logic [1:0]  oh;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    e203_nice_csr_arb_if if_a ();
    e203_nice_csr_arb_if if_b ();

    e203_nice_csr_arb #(.N_REQ(2), .TO_CYC(16), .TO_W(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(vld_a), .req_ready(rr_a),
        .req_addr(addr), .req_wr(wr), .req_wdata(wdata),
        .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(err_a), .csr(if_a)
    );

    e203_nice_csr_arb #(.N_REQ(2), .TO_CYC(4), .TO_W(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(vld_b), .req_ready(rr_b),
        .req_addr(addr), .req_wr(wr), .req_wdata(wdata),
        .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(err_b), .csr(if_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_vld(input bit b, input logic [1:0] v);
        if (b) vld_b = v; else vld_a = v;
    endtask

    task automatic set_rdy(input bit b, input logic r, input logic [31:0] d);
        if (b) begin if_b.nice_csr_ready = r; if_b.nice_csr_rdata = d; end
        else   begin if_a.nice_csr_ready = r; if_a.nice_csr_rdata = d; end
    endtask

    task automatic chk_issue(input bit b, input string tag, input logic [31:0] a,
                             input logic w, input logic [31:0] d);
        chk({tag, "_csr_vld"},   32'(b ? if_b.nice_csr_valid : if_a.nice_csr_valid), 32'd1);
        chk({tag, "_csr_addr"},  b ? if_b.nice_csr_addr  : if_a.nice_csr_addr, a);
        chk({tag, "_csr_wr"},    32'(b ? if_b.nice_csr_wr : if_a.nice_csr_wr), 32'(w));
        chk({tag, "_csr_wdata"}, b ? if_b.nice_csr_wdata : if_a.nice_csr_wdata, d);
    endtask

    task automatic chk_rsp(input bit b, input string tag);
        exp_t e;
        e = '{oh: 2'b00, rd: 32'd0, err: 1'b0};
        if (b) begin if (q_b.size() != 0) e = q_b.pop_front(); end
        else   begin if (q_a.size() != 0) e = q_a.pop_front(); end
        chk({tag, "_rsp_valid"}, 32'(b ? rv_b : rv_a), 32'(e.oh));
        chk({tag, "_rsp_rdata"}, b ? rd_b : rd_a, e.rd);
        chk({tag, "_rsp_err"},   32'(b ? err_b : err_a), 32'(e.err));
        chk({tag, "_csr_vld_off"}, 32'(b ? if_b.nice_csr_valid : if_a.nice_csr_valid), 32'd0);
    endtask

    // One transaction from requester idx: stall ISSUE cycles with ready low, then either
    // ready with rdata rd, or (to=1) no ready at all so the timeout must fire.
    task automatic txn(input bit b, input int idx, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input int stall, input bit to,
                       input logic [31:0] rd, input string tag);
        exp_t       e;
        logic [1:0] oh;
        oh = 2'(1 << idx);
        addr[32*idx +: 32]  = a;
        wdata[32*idx +: 32] = d;
        wr[idx]             = w;
        set_rdy(b, 1'b0, rd);
        set_vld(b, oh);
        #1;
        chk({tag, "_gnt"}, 32'(b ? rr_b : rr_a), 32'(oh));
        e.oh  = oh;
        e.rd  = (to || w) ? 32'd0 : rd;
        e.err = to;
        if (b) q_b.push_back(e); else q_a.push_back(e);
        @(negedge clk);
        set_vld(b, 2'b00);
        for (int k = 0; k < stall; k++) begin
            chk_issue(b, tag, a, w, d);
            chk({tag, "_no_rsp"}, 32'(b ? rv_b : rv_a), 32'd0);
            @(negedge clk);
        end
        if (!to) begin
            set_rdy(b, 1'b1, rd);
            #1;
            chk_issue(b, tag, a, w, d);
            @(negedge clk);
            set_rdy(b, 1'b0, 32'hFFFF_FFFF);
        end
        chk_rsp(b, tag);
        @(negedge clk);
    endtask

    initial begin
        vld_a = '0; vld_b = '0; wr = '0; addr = '0; wdata = '0;
        set_rdy(1'b0, 1'b0, 32'd0);
        set_rdy(1'b1, 1'b0, 32'd0);
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_req_ready_a", 32'(rr_a), 32'd0);
        chk("rst_rsp_valid_a", 32'(rv_a), 32'd0);
        chk("rst_csr_vld_a",   32'(if_a.nice_csr_valid), 32'd0);
        chk("rst_csr_addr_a",  if_a.nice_csr_addr, 32'd0);
        chk("rst_rsp_rdata_a", rd_a, 32'd0);
        chk("rst_rsp_err_a",   32'(err_a), 32'd0);
        chk("rst_csr_vld_b",   32'(if_b.nice_csr_valid), 32'd0);
        chk("rst_rsp_valid_b", 32'(rv_b), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        txn(1'b0, 0, 1'b0, 32'h7C0, 32'd0, 0, 1'b0, 32'hA5A5_0001, "single_rd");
        txn(1'b0, 1, 1'b1, 32'h7C1, 32'hDEAD_BEEF, 5, 1'b0, 32'hFFFF_FFFF, "backpressure");

        // Round robin: both hold valid; last winner was 1, so order is 0,1,0,1
        addr[31:0] = 32'h300; addr[63:32] = 32'h301; wr = 2'b00;
        vld_a = 2'b11;
        for (int i = 0; i < 4; i++) begin
            rr_oh = (i % 2 == 0) ? 2'b01 : 2'b10;
            set_rdy(1'b0, 1'b1, 32'hC0DE_0000 + 32'(i));
            #1;
            chk("rr_gnt", 32'(rr_a), 32'(rr_oh));
            q_a.push_back('{oh: rr_oh, rd: 32'hC0DE_0000 + 32'(i), err: 1'b0});
            @(negedge clk);
            chk("rr_addr", if_a.nice_csr_addr, rr_oh[1] ? 32'h301 : 32'h300);
            @(negedge clk);
            chk_rsp(1'b0, "rr");
            @(negedge clk);
        end
        vld_a = 2'b00;
        set_rdy(1'b0, 1'b0, 32'd0);

        txn(1'b1, 0, 1'b0, 32'h400, 32'd0, 4, 1'b1, 32'hFFFF_0000, "timeout");
        txn(1'b1, 1, 1'b0, 32'h401, 32'd0, 0, 1'b0, 32'h0000_0055, "after_timeout");
        txn(1'b1, 0, 1'b0, 32'h402, 32'd0, 3, 1'b0, 32'h0000_1234, "ready_vs_timeout");

        // Reset in ISSUE after requester 0 won: without reset requester 1 would win next
        addr[31:0] = 32'h500; wr = 2'b00;
        vld_a = 2'b01;
        #1;
        chk("mid_gnt", 32'(rr_a), 32'd1);
        @(negedge clk);
        vld_a = 2'b00;
        chk("mid_csr_vld", 32'(if_a.nice_csr_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_async_vld", 32'(if_a.nice_csr_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("mid_rst_no_rsp", 32'(rv_a), 32'd0);
            @(negedge clk);
        end
        addr[31:0] = 32'h600; addr[63:32] = 32'h601;
        vld_a = 2'b11;
        set_rdy(1'b0, 1'b1, 32'h0000_0099);
        #1;
        chk("post_rst_gnt", 32'(rr_a), 32'd1);
        q_a.push_back('{oh: 2'b01, rd: 32'h0000_0099, err: 1'b0});
        @(negedge clk);
        vld_a = 2'b00;
        chk("post_rst_addr", if_a.nice_csr_addr, 32'h600);
        @(negedge clk);
        chk_rsp(1'b0, "post_rst");
        @(negedge clk);

        chk("sb_a_drained", 32'(q_a.size()), 32'd0);
        chk("sb_b_drained", 32'(q_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
